calc_keypad_encoder: RTL and testbench
======================================

Name: calc_keypad_encoder

Overview:
- Front end for the 4-digit BCD calculator. Scans a 4x4 matrix keypad, debounces it, and encodes each accepted keypress into the calculator's command interface.
- That interface is d_in plus single-cycle ent/pls/mns/eq pulses and a clear pulse.
- Enforces the calculator's entry rules: at most 4 digits per operand, no digits after eq until cleared.
- Sits between the board keypad pins and the calculator core.

Parameters:
- SCAN_DIV, 1000: clock cycles each row is driven (row dwell); must be >= 4.
- DEBOUNCE_SCANS, 4: consecutive identical full scans required to accept a press or a release; must be >= 1.
- MAX_DIGITS, 4: maximum digits accepted per operand.

Ports:
- clk  in  1  system clock; all state on rising edge.
- clr  in  1  reset, asynchronous, active-high.
- col_n  in  4  keypad columns, active-low, pulled up; asynchronous to clk.
- row_n  out  4  keypad row drive, one-hot active-low.
- d_in  out  4  BCD digit of the last accepted digit key; stable until the next accepted digit.
- ent  out  1  one-cycle pulse; d_in valid in the same cycle.
- pls  out  1  one-cycle pulse, '+' key.
- mns  out  1  one-cycle pulse, '-' key.
- eq  out  1  one-cycle pulse, '=' key.
- clr_key  out  1  one-cycle pulse, 'C' key (drives calculator clr).
- key_err  out  1  one-cycle pulse when an accepted key is rejected by entry rules.

Behaviour:
- Reset values (async on clr):
  - row_n=4'b1110 (row0 driven), d_in=0.
  - All pulse outputs 0.
  - FSM in IDLE; digit count 0; lock 0; dwell and debounce counters 0.
- Column sync: col_n passes through a 2-flop synchroniser before any use.
- Scanning:
  - Dwell counter counts 0..SCAN_DIV-1 per row.
  - The synchronised columns are sampled on the last dwell cycle, then the row rotates 0->1->2->3->0.
  - A full scan is 4*SCAN_DIV cycles.
  - Scanning never stops, including during pulse emission.
- Key map (row,col):
  - r0: 1 2 3 +
  - r1: 4 5 6 -
  - r2: 7 8 9 =
  - r3: C 0 none none
  - r3c2 and r3c3 are unused; pressing them counts as "no key".
- Scan result, evaluated at the end of row3's sample:
  - NONE: zero keys low.
  - KEY(code): exactly one mapped key low.
  - MULTI: two or more keys low anywhere in the scan.
- FSM (advances once per scan end):
  - IDLE:
    - KEY -> DEBOUNCE with cnt=1 and the code latched.
    - NONE or MULTI -> stay.
  - DEBOUNCE:
    - Same KEY -> cnt+1; when cnt reaches DEBOUNCE_SCANS, go to HELD and emit.
    - Different KEY -> restart with cnt=1 and the new code latched.
    - NONE or MULTI -> IDLE.
  - HELD:
    - Any KEY or MULTI -> stay, with no repeat (no auto-repeat).
    - NONE -> RELEASE with cnt=1.
  - RELEASE:
    - NONE -> cnt+1; at DEBOUNCE_SCANS go to IDLE.
    - KEY or MULTI -> HELD.
- DEBOUNCE_SCANS=1 accepts a press on its first KEY scan (IDLE -> HELD directly).
- Emission: exactly one pulse, in the clk cycle after the scan-end evaluation that reaches HELD.
- Entry rules:
  - Digit:
    - If lock=0 and count<MAX_DIGITS: d_in<=digit, ent, count+1.
    - Otherwise: key_err, and d_in is unchanged.
  - '+' / '-': pls / mns; count<=0; lock unchanged.
  - '=': eq; lock<=1.
  - 'C': clr_key; count<=0; lock<=0.
- Only one output pulse is ever high in a given cycle; the next pulse requires a full release.
- clr asserted mid-scan or mid-debounce: all state returns to its reset value. Scanning resumes at row0 on the first clk after clr deasserts.

Decomposition:
- Shared package (calc_pkg) holds:
  - Key code constants: K_0..K_9 = 4'd0..4'd9, K_PLS=10, K_MNS=11, K_EQ=12, K_CLR=13.
  - The scan-result enum NONE/KEY/MULTI.
  - The FSM state enum IDLE/DEBOUNCE/HELD/RELEASE.
- Sub-module keypad_scanner: dwell counter, row rotation, synchroniser, per-scan key capture, and the scan_done/result/code outputs.
- Debounce FSM and entry rules live in the top module.

Test Plan (SCAN_DIV=4, DEBOUNCE_SCANS=2, so a full scan is 16 cycles):
- Reset: clr held mid-scan -> row_n=1110 and all pulses 0. After release, row_n rotates every 4 cycles (1110, 1101, 1011, 0111).
- Digit press: hold r1c1 ('5') for 3 scans -> exactly one ent with d_in=5, one cycle after the end of the 2nd scan. Release for 2 scans, then press '5' again -> a second ent.
- Bounce: '7' present for 1 scan, absent for 1 scan, repeated 4 times -> no pulse.
- Sequence 1,2,3,4,5,'+',9,'=',3,'C',6 (each pressed and released cleanly):
  - ent for digits 1-4.
  - key_err on 5.
  - pls.
  - ent with d_in=9.
  - eq.
  - key_err on 3 (locked).
  - clr_key.
  - ent with d_in=6.
- Multi-key: '1' and '9' held together -> no pulse. Release '9' while still holding '1' -> one ent with d_in=1 after 2 scans.
- Unused key r3c3 held for 5 scans -> no pulse and no key_err.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared definitions for the calculator keypad front end: key codes,
// scan-result and debounce-state encodings, and the keypad map.
package calc_pkg;

    localparam logic [3:0] K_0   = 4'd0;
    localparam logic [3:0] K_1   = 4'd1;
    localparam logic [3:0] K_2   = 4'd2;
    localparam logic [3:0] K_3   = 4'd3;
    localparam logic [3:0] K_4   = 4'd4;
    localparam logic [3:0] K_5   = 4'd5;
    localparam logic [3:0] K_6   = 4'd6;
    localparam logic [3:0] K_7   = 4'd7;
    localparam logic [3:0] K_8   = 4'd8;
    localparam logic [3:0] K_9   = 4'd9;
    localparam logic [3:0] K_PLS = 4'd10;
    localparam logic [3:0] K_MNS = 4'd11;
    localparam logic [3:0] K_EQ  = 4'd12;
    localparam logic [3:0] K_CLR = 4'd13;

    typedef enum logic [1:0] {
        NONE,
        KEY,
        MULTI
    } scan_res_e;

    typedef enum logic [1:0] {
        IDLE,
        DEBOUNCE,
        HELD,
        RELEASE
    } kp_state_e;

    // Row 3 columns 2 and 3 are unpopulated; callers mask them before lookup.
    function automatic logic [3:0] key_code(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] code;
        code = K_0;
        case ({row, col})
            4'h0:    code = K_1;
            4'h1:    code = K_2;
            4'h2:    code = K_3;
            4'h3:    code = K_PLS;
            4'h4:    code = K_4;
            4'h5:    code = K_5;
            4'h6:    code = K_6;
            4'h7:    code = K_MNS;
            4'h8:    code = K_7;
            4'h9:    code = K_8;
            4'hA:    code = K_9;
            4'hB:    code = K_EQ;
            4'hC:    code = K_CLR;
            4'hD:    code = K_0;
            default: code = K_0;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/keypad_scanner.sv
// Row scanner for a 4x4 active-low keypad: drives rows in turn, samples the
// synchronised columns once per row, and reports one result per full scan.
module keypad_scanner
    import calc_pkg::*;
#(
    parameter int SCAN_DIV = 1000
) (
    input  logic       clk,
    input  logic       clr,
    input  logic [3:0] col_n,
    output logic [3:0] row_n,
    output logic       scan_done,
    output scan_res_e  scan_res,
    output logic [3:0] scan_code
);

    localparam int DW = $clog2(SCAN_DIV);
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);

    logic [3:0]    col_s1_q, col_s2_q;
    logic [DW-1:0] dwell_q, dwell_d;
    logic [1:0]    row_q, row_d;
    logic [1:0]    hits_q, hits_d;
    logic [3:0]    code_q, code_d;
    logic          done_q, done_d;
    scan_res_e     res_q, res_d;
    logic [3:0]    out_code_q, out_code_d;

    logic          last;
    logic [3:0]    pressed;
    logic [2:0]    row_hits;
    logic [2:0]    sum_w;
    logic [1:0]    sum_sat;
    logic [1:0]    first_col;
    logic [3:0]    new_code;

    always_comb begin
        last      = (dwell_q == DWELL_LAST);
        pressed   = ~col_s2_q & ((row_q == 2'd3) ? 4'b0011 : 4'b1111);
        row_hits  = {2'b0, pressed[0]} + {2'b0, pressed[1]} +
                    {2'b0, pressed[2]} + {2'b0, pressed[3]};
        sum_w     = {1'b0, hits_q} + row_hits;
        // Counts saturate at 2: anything beyond one key is simply MULTI.
        sum_sat   = (sum_w >= 3'd2) ? 2'd2 : sum_w[1:0];
        first_col = 2'd0;
        if (pressed[0])      first_col = 2'd0;
        else if (pressed[1]) first_col = 2'd1;
        else if (pressed[2]) first_col = 2'd2;
        else if (pressed[3]) first_col = 2'd3;
        new_code  = (hits_q == 2'd0 && row_hits == 3'd1) ? key_code(row_q, first_col) : code_q;

        dwell_d    = last ? '0 : dwell_q + 1'b1;
        row_d      = last ? row_q + 2'd1 : row_q;
        hits_d     = hits_q;
        code_d     = code_q;
        done_d     = 1'b0;
        res_d      = res_q;
        out_code_d = out_code_q;

        if (last) begin
            if (row_q == 2'd3) begin
                done_d     = 1'b1;
                res_d      = (sum_sat == 2'd0) ? NONE : (sum_sat == 2'd1) ? KEY : MULTI;
                out_code_d = new_code;
                hits_d     = 2'd0;
                code_d     = K_0;
            end else begin
                hits_d = sum_sat;
                code_d = new_code;
            end
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            col_s1_q   <= 4'hF;
            col_s2_q   <= 4'hF;
            dwell_q    <= '0;
            row_q      <= 2'd0;
            hits_q     <= 2'd0;
            code_q     <= K_0;
            done_q     <= 1'b0;
            res_q      <= NONE;
            out_code_q <= K_0;
        end else begin
            col_s1_q   <= col_n;
            col_s2_q   <= col_s1_q;
            dwell_q    <= dwell_d;
            row_q      <= row_d;
            hits_q     <= hits_d;
            code_q     <= code_d;
            done_q     <= done_d;
            res_q      <= res_d;
            out_code_q <= out_code_d;
        end
    end

    assign row_n     = ~(4'b0001 << row_q);
    assign scan_done = done_q;
    assign scan_res  = res_q;
    assign scan_code = out_code_q;

endmodule

// File: rtl/calc_keypad_encoder.sv
// Keypad front end for the BCD calculator: debounces scanner results and
// turns each accepted press into one command pulse, enforcing entry rules.
module calc_keypad_encoder
    import calc_pkg::*;
#(
    parameter int SCAN_DIV       = 1000,
    parameter int DEBOUNCE_SCANS = 4,
    parameter int MAX_DIGITS     = 4
) (
    input  logic       clk,
    input  logic       clr,
    input  logic [3:0] col_n,
    output logic [3:0] row_n,
    output logic [3:0] d_in,
    output logic       ent,
    output logic       pls,
    output logic       mns,
    output logic       eq,
    output logic       clr_key,
    output logic       key_err
);

    localparam int CNT_W = 16;
    localparam int DC_W  = $clog2(MAX_DIGITS + 1);
    localparam logic [CNT_W-1:0] DB_LIM = CNT_W'(DEBOUNCE_SCANS);
    localparam logic [DC_W-1:0]  DIG_LIM = DC_W'(MAX_DIGITS);

    logic       scan_done;
    scan_res_e  scan_res;
    logic [3:0] scan_code;

    keypad_scanner #(.SCAN_DIV(SCAN_DIV)) u_scanner (
        .clk       (clk),
        .clr       (clr),
        .col_n     (col_n),
        .row_n     (row_n),
        .scan_done (scan_done),
        .scan_res  (scan_res),
        .scan_code (scan_code)
    );

    kp_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       key_q, key_d;
    logic [DC_W-1:0]  dcnt_q, dcnt_d;
    logic             lock_q, lock_d;
    logic [3:0]       d_in_q, d_in_d;
    logic             ent_q, ent_d, pls_q, pls_d, mns_q, mns_d;
    logic             eq_q, eq_d, clr_key_q, clr_key_d, key_err_q, key_err_d;
    logic             emit;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        key_d     = key_q;
        dcnt_d    = dcnt_q;
        lock_d    = lock_q;
        d_in_d    = d_in_q;
        ent_d     = 1'b0;
        pls_d     = 1'b0;
        mns_d     = 1'b0;
        eq_d      = 1'b0;
        clr_key_d = 1'b0;
        key_err_d = 1'b0;
        emit      = 1'b0;

        if (scan_done) begin
            case (state_q)
                IDLE: begin
                    if (scan_res == KEY) begin
                        key_d = scan_code;
                        cnt_d = CNT_W'(1);
                        if (DEBOUNCE_SCANS == 1) begin
                            state_d = HELD;
                            emit    = 1'b1;
                        end else begin
                            state_d = DEBOUNCE;
                        end
                    end
                end
                DEBOUNCE: begin
                    if (scan_res != KEY) begin
                        state_d = IDLE;
                    end else if (scan_code != key_q) begin
                        key_d = scan_code;
                        cnt_d = CNT_W'(1);
                    end else if (cnt_q + 1'b1 >= DB_LIM) begin
                        state_d = HELD;
                        emit    = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                HELD: begin
                    // Held keys never repeat; only a full release re-arms.
                    if (scan_res == NONE) begin
                        cnt_d   = CNT_W'(1);
                        state_d = (DEBOUNCE_SCANS == 1) ? IDLE : RELEASE;
                    end
                end
                RELEASE: begin
                    if (scan_res != NONE) begin
                        state_d = HELD;
                    end else if (cnt_q + 1'b1 >= DB_LIM) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        if (emit) begin
            case (scan_code)
                K_PLS: begin
                    pls_d  = 1'b1;
                    dcnt_d = '0;
                end
                K_MNS: begin
                    mns_d  = 1'b1;
                    dcnt_d = '0;
                end
                K_EQ: begin
                    eq_d   = 1'b1;
                    lock_d = 1'b1;
                end
                K_CLR: begin
                    clr_key_d = 1'b1;
                    dcnt_d    = '0;
                    lock_d    = 1'b0;
                end
                default: begin
                    if (!lock_q && dcnt_q < DIG_LIM) begin
                        d_in_d = scan_code;
                        ent_d  = 1'b1;
                        dcnt_d = dcnt_q + 1'b1;
                    end else begin
                        key_err_d = 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            key_q     <= K_0;
            dcnt_q    <= '0;
            lock_q    <= 1'b0;
            d_in_q    <= 4'd0;
            ent_q     <= 1'b0;
            pls_q     <= 1'b0;
            mns_q     <= 1'b0;
            eq_q      <= 1'b0;
            clr_key_q <= 1'b0;
            key_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            key_q     <= key_d;
            dcnt_q    <= dcnt_d;
            lock_q    <= lock_d;
            d_in_q    <= d_in_d;
            ent_q     <= ent_d;
            pls_q     <= pls_d;
            mns_q     <= mns_d;
            eq_q      <= eq_d;
            clr_key_q <= clr_key_d;
            key_err_q <= key_err_d;
        end
    end

    assign d_in    = d_in_q;
    assign ent     = ent_q;
    assign pls     = pls_q;
    assign mns     = mns_q;
    assign eq      = eq_q;
    assign clr_key = clr_key_q;
    assign key_err = key_err_q;

endmodule

// File: tb/tb_calc_keypad_encoder.sv
// Directed bench for calc_keypad_encoder with a behavioural 4x4 keypad
// (SCAN_DIV=4, DEBOUNCE_SCANS=2: one full scan every 16 clocks).
module tb_calc_keypad_encoder;

    localparam int SCAN = 16;

    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic [3:0] col_n;
    logic [3:0] row_n;
    logic [3:0] d_in;
    logic       ent, pls, mns, eq, clr_key, key_err;

    // keys[r*4+c] = 1 means the switch at row r, column c is closed.
    logic [15:0] keys = 16'h0000;

    int checks   = 0;
    int failures = 0;

    int n_ent = 0, n_err = 0, n_pls = 0, n_mns = 0, n_eq = 0, n_clr = 0, n_overlap = 0;

    calc_keypad_encoder #(
        .SCAN_DIV       (4),
        .DEBOUNCE_SCANS (2),
        .MAX_DIGITS     (4)
    ) dut (
        .clk     (clk),
        .clr     (clr),
        .col_n   (col_n),
        .row_n   (row_n),
        .d_in    (d_in),
        .ent     (ent),
        .pls     (pls),
        .mns     (mns),
        .eq      (eq),
        .clr_key (clr_key),
        .key_err (key_err)
    );

    always #5 clk = ~clk;

    always_comb begin
        col_n = 4'hF;
        for (int r = 0; r < 4; r++)
            if (!row_n[r]) col_n = col_n & ~keys[r*4 +: 4];
    end

    always @(negedge clk) begin
        if (ent)     n_ent++;
        if (key_err) n_err++;
        if (pls)     n_pls++;
        if (mns)     n_mns++;
        if (eq)      n_eq++;
        if (clr_key) n_clr++;
        if ($countones({ent, pls, mns, eq, clr_key, key_err}) > 1) n_overlap++;
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic scans(input int n);
        cyc(SCAN * n);
    endtask

    task automatic press(input int idx);
        keys = 16'h0000;
        keys[idx] = 1'b1;
        scans(3);
        keys = 16'h0000;
        scans(2);
    endtask

    function automatic int total_pulses();
        return n_ent + n_err + n_pls + n_mns + n_eq + n_clr;
    endfunction

    task automatic test_reset();
        logic [3:0] exp_rows [4];
        exp_rows = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        clr = 1'b1;
        cyc(3);
        checks++;
        if (row_n !== 4'b1110 || d_in !== 4'd0) begin
            failures++;
            $display("FAIL reset_initial row_n=%b d_in=%0d expected row_n=1110 d_in=0", row_n, d_in);
        end
        clr = 1'b0;
        cyc(6);
        clr = 1'b1;
        cyc(3);
        checks++;
        if (row_n !== 4'b1110 || {ent, pls, mns, eq, clr_key, key_err} !== 6'b0) begin
            failures++;
            $display("FAIL reset_midscan row_n=%b pulses=%b expected 1110/000000",
                     row_n, {ent, pls, mns, eq, clr_key, key_err});
        end
        clr = 1'b0;
        cyc(2);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (row_n !== exp_rows[i]) begin
                failures++;
                $display("FAIL row_rotate%0d row_n=%b expected %b", i, row_n, exp_rows[i]);
            end
            cyc(i < 3 ? 4 : 2);
        end
    endtask

    task automatic test_digit();
        int e0;
        e0 = n_ent;
        keys = 16'h0000;
        keys[5] = 1'b1;
        scans(2);
        checks++;
        if (ent !== 1'b0) begin
            failures++;
            $display("FAIL digit_early ent=%b expected 0", ent);
        end
        cyc(1);
        checks++;
        if (ent !== 1'b1 || d_in !== 4'd5) begin
            failures++;
            $display("FAIL digit_latency ent=%b d_in=%0d expected ent=1 d_in=5", ent, d_in);
        end
        cyc(SCAN - 1);
        keys = 16'h0000;
        scans(2);
        checks++;
        if (n_ent - e0 !== 1) begin
            failures++;
            $display("FAIL digit_once ents=%0d expected 1", n_ent - e0);
        end
        press(5);
        checks++;
        if (n_ent - e0 !== 2 || d_in !== 4'd5) begin
            failures++;
            $display("FAIL digit_repress ents=%0d d_in=%0d expected 2/5", n_ent - e0, d_in);
        end
    endtask

    task automatic test_clr_mid_debounce();
        int p0;
        p0 = total_pulses();
        keys = 16'h0000;
        keys[5] = 1'b1;
        scans(1);
        cyc(3);
        clr = 1'b1;
        cyc(2);
        checks++;
        if (row_n !== 4'b1110 || d_in !== 4'd0) begin
            failures++;
            $display("FAIL clr_debounce_state row_n=%b d_in=%0d expected 1110/0", row_n, d_in);
        end
        clr = 1'b0;
        scans(1);
        keys = 16'h0000;
        scans(2);
        checks++;
        if (total_pulses() - p0 !== 0) begin
            failures++;
            $display("FAIL clr_debounce_pulse pulses=%0d expected 0", total_pulses() - p0);
        end
    endtask

    task automatic test_bounce();
        int p0;
        p0 = total_pulses();
        for (int i = 0; i < 4; i++) begin
            keys = 16'h0000;
            keys[8] = 1'b1;
            scans(1);
            keys = 16'h0000;
            scans(1);
        end
        scans(1);
        checks++;
        if (total_pulses() - p0 !== 0) begin
            failures++;
            $display("FAIL bounce pulses=%0d expected 0", total_pulses() - p0);
        end
    endtask

    task automatic test_sequence();
        // Keys 1,2,3,4,5,+,9,=,3,C,6; kind 0=ent 1=err 2=pls 3=eq 4=clr_key.
        int         idx  [11] = '{0, 1, 2, 4, 5, 3, 10, 11, 2, 12, 6};
        int         kind [11] = '{0, 0, 0, 0, 1, 2, 0, 3, 1, 4, 0};
        logic [3:0] dexp [11] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd4, 4'd4, 4'd9, 4'd9, 4'd9, 4'd9, 4'd6};
        int e0, r0, p0, m0, q0, c0;
        logic [5:0] got, want;
        for (int i = 0; i < 11; i++) begin
            e0 = n_ent; r0 = n_err; p0 = n_pls; m0 = n_mns; q0 = n_eq; c0 = n_clr;
            press(idx[i]);
            got  = {(n_ent - e0) == 1, (n_err - r0) == 1, (n_pls - p0) == 1,
                    (n_mns - m0) == 1, (n_eq - q0) == 1, (n_clr - c0) == 1};
            want = 6'b0;
            want[5 - kind[i] - (kind[i] >= 3 ? 1 : 0)] = 1'b1;
            checks++;
            if (got !== want || (n_ent - e0) + (n_err - r0) + (n_pls - p0) + (n_mns - m0) +
                (n_eq - q0) + (n_clr - c0) != 1) begin
                failures++;
                $display("FAIL seq%0d_pulse ent/err/pls/mns/eq/clr=%b expected %b", i, got, want);
            end
            checks++;
            if (d_in !== dexp[i]) begin
                failures++;
                $display("FAIL seq%0d_d_in d_in=%0d expected %0d", i, d_in, dexp[i]);
            end
        end
    endtask

    task automatic test_multi();
        int p0, e0;
        p0 = total_pulses();
        keys = 16'h0000;
        keys[0]  = 1'b1;
        keys[10] = 1'b1;
        scans(3);
        checks++;
        if (total_pulses() - p0 !== 0) begin
            failures++;
            $display("FAIL multi_hold pulses=%0d expected 0", total_pulses() - p0);
        end
        e0 = n_ent;
        keys[10] = 1'b0;
        scans(3);
        checks++;
        if (n_ent - e0 !== 1 || total_pulses() - p0 !== 1 || d_in !== 4'd1) begin
            failures++;
            $display("FAIL multi_release ents=%0d pulses=%0d d_in=%0d expected 1/1/1",
                     n_ent - e0, total_pulses() - p0, d_in);
        end
        keys = 16'h0000;
        scans(2);
    endtask

    task automatic test_unused_key();
        int p0;
        p0 = total_pulses();
        keys = 16'h0000;
        keys[15] = 1'b1;
        scans(5);
        keys = 16'h0000;
        scans(2);
        checks++;
        if (total_pulses() - p0 !== 0 || d_in !== 4'd1) begin
            failures++;
            $display("FAIL unused_key pulses=%0d d_in=%0d expected 0/1", total_pulses() - p0, d_in);
        end
    endtask

    task automatic test_one_hot();
        checks++;
        if (n_overlap !== 0) begin
            failures++;
            $display("FAIL pulse_overlap cycles=%0d expected 0", n_overlap);
        end
    endtask

    initial begin
        test_reset();
        test_digit();
        test_clr_mid_debounce();
        test_bounce();
        test_sequence();
        test_multi();
        test_unused_key();
        test_one_hot();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
